// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory bus: controller states, RAM size default
// and the RW_ encoding used by the RAM and the CPU decode.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int MEM_DEPTH_DEF = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_bus_master_if.sv
// Request/response channels from the CPU plus the RAM pins, bundled for the bus master.
interface mem_bus_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Handshake rule for both req and resp: a transfer happens on a rising clk edge
    // where valid and ready are both high; the source holds valid and payload stable
    // until that edge, and ready never depends combinationally on valid.
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic              mem_cs;
    logic              mem_rw_;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_cs, mem_rw_, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_cs, mem_rw_, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_bus_master.sv
// Data-memory bus initiator: one load/store in flight, range check, optional read
// byte swap, all outputs registered.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_DEPTH    = MEM_DEPTH_DEF,
    parameter int WAIT_CYCLES  = 0,
    parameter int RD_BYTE_SWAP = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_bus_master_if.master bus,
    output state_e          state_o
);

    localparam logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'(MEM_DEPTH - 2);
    localparam logic [2:0]        WAIT_INIT = 3'(WAIT_CYCLES);
    localparam int                HALF_W    = DATA_W / 2;

    state_e            state_q, state_d;
    logic [2:0]        wait_q, wait_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_cs_q, mem_cs_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_fmt;

    // The RAM hands back the byte at addr in the low half; swap to put it on top.
    assign rdata_fmt = (RD_BYTE_SWAP != 0)
                     ? {bus.mem_rdata[HALF_W-1:0], bus.mem_rdata[DATA_W-1:HALF_W]}
                     : bus.mem_rdata;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_cs_d     = mem_cs_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    mem_addr_d  = bus.req_addr;
                    mem_wdata_d = bus.req_wdata;
                    if (bus.req_addr > MAX_ADDR) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d  = ACCESS;
                        mem_cs_d = 1'b1;
                        mem_rw_d = bus.req_we ? RW_WRITE : RW_READ;
                        wait_d   = WAIT_INIT;
                    end
                end
            end
            ACCESS: begin
                if (wait_q == 3'd0) begin
                    state_d      = RESP;
                    mem_cs_d     = 1'b0;
                    mem_rw_d     = RW_READ;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = (mem_rw_q == RW_READ) ? rdata_fmt : '0;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_q       <= 3'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_cs_q     <= 1'b0;
            mem_rw_q     <= RW_READ;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_cs_q     <= mem_cs_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_cs     = mem_cs_q;
    assign bus.mem_rw_    = mem_rw_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: one instance with no wait states, one with three,
// each attached to a small byte-addressed RAM model.
module tb_mem_bus_master;
    import mem_bus_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_e st0, st3;
    int     n_cmp = 0;
    int     n_bad = 0;

    logic [7:0]  ram0 [16];
    logic [7:0]  ram3 [16];
    logic [7:0]  model [16];
    logic [15:0] exp_q [$];

    mem_bus_master_if #(.ADDR_W(16), .DATA_W(16)) b0 ();
    mem_bus_master_if #(.ADDR_W(16), .DATA_W(16)) b3 ();

    mem_bus_master #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0), .state_o(st0));
    mem_bus_master #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3), .state_o(st3));

    always #5 clk = ~clk;

    // RAM: stores big-endian (byte[a] = data[15:8]), returns {byte[a+1], byte[a]}
    logic [3:0] a0, a3;
    assign a0 = b0.mem_addr[3:0];
    assign a3 = b3.mem_addr[3:0];
    assign b0.mem_rdata = (b0.mem_cs && b0.mem_rw_) ? {ram0[a0 + 4'd1], ram0[a0]} : 16'h0000;
    assign b3.mem_rdata = (b3.mem_cs && b3.mem_rw_) ? {ram3[a3 + 4'd1], ram3[a3]} : 16'h0000;

    always @(posedge clk) begin
        if (b0.mem_cs && !b0.mem_rw_) begin
            ram0[a0]        <= b0.mem_wdata[15:8];
            ram0[a0 + 4'd1] <= b0.mem_wdata[7:0];
        end
        if (b3.mem_cs && !b3.mem_rw_) begin
            ram3[a3]        <= b3.mem_wdata[15:8];
            ram3[a3 + 4'd1] <= b3.mem_wdata[7:0];
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        b0.req_valid = 1'b1;
        b0.req_we    = we;
        b0.req_addr  = addr;
        b0.req_wdata = wdata;
    endtask

    initial begin
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_d;

        for (int i = 0; i < 16; i++) begin
            ram0[i] = 8'h00;
            ram3[i] = 8'h00;
        end
        ram3[14] = 8'hC3;
        ram3[15] = 8'h3C;
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
        b0.resp_ready = 1'b0;
        b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_addr = '0; b3.req_wdata = '0;
        b3.resp_ready = 1'b0;

        // Reset values
        step(2);
        check("rst_state", 32'(st0), 32'(IDLE));
        check("rst_req_ready", 32'(b0.req_ready), 32'd1);
        check("rst_resp_valid", 32'(b0.resp_valid), 32'd0);
        check("rst_resp_rdata", 32'(b0.resp_rdata), 32'd0);
        check("rst_resp_err", 32'(b0.resp_err), 32'd0);
        check("rst_mem_cs", 32'(b0.mem_cs), 32'd0);
        check("rst_mem_rw_", 32'(b0.mem_rw_), 32'd1);
        check("rst_mem_addr", 32'(b0.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(b0.mem_wdata), 32'd0);
        rst = 1'b0;
        step(1);

        // Store 0xA55A @4
        b0.resp_ready = 1'b1;
        drive_req(1'b1, 16'h0004, 16'hA55A);
        step(1);
        b0.req_valid = 1'b0;
        check("st_cs", 32'(b0.mem_cs), 32'd1);
        check("st_rw_", 32'(b0.mem_rw_), 32'd0);
        check("st_addr", 32'(b0.mem_addr), 32'h4);
        check("st_wdata", 32'(b0.mem_wdata), 32'hA55A);
        check("st_req_ready", 32'(b0.req_ready), 32'd0);
        check("st_resp_early", 32'(b0.resp_valid), 32'd0);
        step(1);
        check("st_cs_drop", 32'(b0.mem_cs), 32'd0);
        check("st_rw_idle", 32'(b0.mem_rw_), 32'd1);
        check("st_resp_valid", 32'(b0.resp_valid), 32'd1);
        check("st_rdata", 32'(b0.resp_rdata), 32'd0);
        check("st_err", 32'(b0.resp_err), 32'd0);
        step(1);
        check("st_resp_clear", 32'(b0.resp_valid), 32'd0);
        check("st_req_ready_back", 32'(b0.req_ready), 32'd1);
        check("st_ram_hi", 32'(ram0[4]), 32'hA5);
        check("st_ram_lo", 32'(ram0[5]), 32'h5A);

        // Load @4
        drive_req(1'b0, 16'h0004, 16'h0000);
        step(1);
        b0.req_valid = 1'b0;
        check("ld_cs", 32'(b0.mem_cs), 32'd1);
        check("ld_rw_", 32'(b0.mem_rw_), 32'd1);
        step(1);
        check("ld_cs_drop", 32'(b0.mem_cs), 32'd0);
        check("ld_resp_valid", 32'(b0.resp_valid), 32'd1);
        check("ld_rdata", 32'(b0.resp_rdata), 32'hA55A);
        check("ld_err", 32'(b0.resp_err), 32'd0);
        step(1);
        check("ld_resp_clear", 32'(b0.resp_valid), 32'd0);

        // Out-of-range loads: first illegal byte address and a far one
        drive_req(1'b0, 16'h000F, 16'h0000);
        step(1);
        b0.req_valid = 1'b0;
        check("err0f_state", 32'(st0), 32'(RESP));
        check("err0f_valid", 32'(b0.resp_valid), 32'd1);
        check("err0f_err", 32'(b0.resp_err), 32'd1);
        check("err0f_rdata", 32'(b0.resp_rdata), 32'd0);
        check("err0f_cs", 32'(b0.mem_cs), 32'd0);
        step(1);
        check("err0f_clear", 32'(b0.resp_valid), 32'd0);
        check("err0f_cs_after", 32'(b0.mem_cs), 32'd0);
        drive_req(1'b0, 16'h0400, 16'h0000);
        step(1);
        b0.req_valid = 1'b0;
        check("err400_valid", 32'(b0.resp_valid), 32'd1);
        check("err400_err", 32'(b0.resp_err), 32'd1);
        check("err400_cs", 32'(b0.mem_cs), 32'd0);
        step(1);
        check("err400_clear", 32'(b0.resp_err), 32'd0);

        // Last legal address with three wait states
        b3.resp_ready = 1'b1;
        b3.req_valid  = 1'b1;
        b3.req_we     = 1'b0;
        b3.req_addr   = 16'h000E;
        step(1);
        b3.req_valid = 1'b0;
        check("w3_cs_t0", 32'(b3.mem_cs), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check("w3_cs_hold", 32'(b3.mem_cs), 32'd1);
            check("w3_resp_wait", 32'(b3.resp_valid), 32'd0);
        end
        step(1);
        check("w3_cs_drop", 32'(b3.mem_cs), 32'd0);
        check("w3_resp_valid", 32'(b3.resp_valid), 32'd1);
        check("w3_rdata", 32'(b3.resp_rdata), 32'hC33C);
        check("w3_err", 32'(b3.resp_err), 32'd0);
        step(1);
        check("w3_resp_clear", 32'(b3.resp_valid), 32'd0);

        // Response back-pressure; a second request stays pending meanwhile
        b0.resp_ready = 1'b0;
        drive_req(1'b0, 16'h0004, 16'h0000);
        step(1);
        drive_req(1'b1, 16'h0008, 16'hBEEF);
        step(1);
        check("bp_resp_valid", 32'(b0.resp_valid), 32'd1);
        check("bp_rdata", 32'(b0.resp_rdata), 32'hA55A);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("bp_hold_valid", 32'(b0.resp_valid), 32'd1);
            check("bp_hold_rdata", 32'(b0.resp_rdata), 32'hA55A);
            check("bp_req_ready", 32'(b0.req_ready), 32'd0);
            check("bp_cs", 32'(b0.mem_cs), 32'd0);
        end
        b0.resp_ready = 1'b1;
        step(1);
        check("bp_hs_valid", 32'(b0.resp_valid), 32'd0);
        check("bp_hs_state", 32'(st0), 32'(IDLE));
        check("bp_hs_cs", 32'(b0.mem_cs), 32'd0);
        step(1);
        b0.req_valid = 1'b0;
        check("bp_second_cs", 32'(b0.mem_cs), 32'd1);
        check("bp_second_rw_", 32'(b0.mem_rw_), 32'd0);
        check("bp_second_addr", 32'(b0.mem_addr), 32'h8);
        step(2);
        check("bp_second_ram", 32'({ram0[8], ram0[9]}), 32'hBEEF);

        // Reset in the middle of a store
        drive_req(1'b1, 16'h0006, 16'h7777);
        step(1);
        b0.req_valid = 1'b0;
        check("rs_cs_before", 32'(b0.mem_cs), 32'd1);
        rst = 1'b1;
        step(1);
        check("rs_cs", 32'(b0.mem_cs), 32'd0);
        check("rs_resp_valid", 32'(b0.resp_valid), 32'd0);
        check("rs_addr", 32'(b0.mem_addr), 32'd0);
        check("rs_state", 32'(st0), 32'(IDLE));
        rst = 1'b0;
        step(1);
        check("rs_req_ready", 32'(b0.req_ready), 32'd1);
        check("rs_no_resp", 32'(b0.resp_valid), 32'd0);

        // Back-to-back random traffic against a byte model of the RAM
        for (int i = 0; i < 16; i++) model[i] = ram0[i];
        for (int k = 0; k < 8; k++) begin
            we    = 1'($urandom_range(0, 1));
            addr  = 16'($urandom_range(0, 14));
            wdata = 16'($urandom_range(0, 65535));
            if (we) begin
                exp_d = 16'h0000;
                model[addr[3:0]]        = wdata[15:8];
                model[addr[3:0] + 4'd1] = wdata[7:0];
            end else begin
                exp_d = {model[addr[3:0]], model[addr[3:0] + 4'd1]};
            end
            exp_q.push_back(exp_d);
            drive_req(we, addr, wdata);
            step(1);
            b0.req_we   = ~we;
            b0.req_addr = 16'hFFFF;
            check("b2b_cs", 32'(b0.mem_cs), 32'd1);
            check("b2b_addr", 32'(b0.mem_addr), 32'(addr));
            step(1);
            check("b2b_valid", 32'(b0.resp_valid), 32'd1);
            check("b2b_rdata", 32'(b0.resp_rdata), 32'(exp_q.pop_front()));
            check("b2b_err", 32'(b0.resp_err), 32'd0);
            step(1);
            check("b2b_ready", 32'(b0.req_ready), 32'd1);
        end
        b0.req_valid = 1'b0;
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
